// File: rtl/pdm_sequencer_pkg.sv
// Shared types and helpers for the PDM setpoint sequencer.
// Optional ramping is enabled with macro PDM_SEQUENCER_RAMP_EN.
package pdm_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widest setpoint the helper supports; callers zero-extend into it.
  localparam int unsigned SP_MAX_W = 32;
  localparam int unsigned SP_EXT_W = SP_MAX_W + 1;

  // One ramp step from cur toward tgt, clamped at tgt; a zero step counts as 1.
  // Working one bit wider than the operands so the sum can never wrap.
  function automatic logic [SP_MAX_W-1:0] next_setpoint(
    input logic [SP_MAX_W-1:0] cur,
    input logic [SP_MAX_W-1:0] tgt,
    input logic [SP_MAX_W-1:0] stp
  );
    logic [SP_EXT_W-1:0] inc;
    logic [SP_EXT_W-1:0] gap;
    logic [SP_EXT_W-1:0] res;
    inc = (stp == '0) ? SP_EXT_W'(1) : {1'b0, stp};
    gap = '0;
    res = {1'b0, tgt};
    if (cur < tgt) begin
      gap = {1'b0, tgt} - {1'b0, cur};
      if (inc < gap) res = {1'b0, cur} + inc;
    end else if (cur > tgt) begin
      gap = {1'b0, cur} - {1'b0, tgt};
      if (inc < gap) res = {1'b0, cur} - inc;
    end
    return SP_MAX_W'(res);
  endfunction

endpackage

// File: rtl/pdm_sequencer_prescaler.sv
// Ramp tick prescaler: counts 0..div and pulses tick_c on the div cycle.
// Held at zero while clr is high so the first tick lands div+1 cycles after release.
module pdm_sequencer_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick_c
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  // Next count: restart on clear or at the end of each period.
  always_comb begin
    count_d = count_q + DIV_W'(1);
    if (clr || (count_q == div)) count_d = '0;
  end

  assign tick_c = !clr && (count_q == div);

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/pdm_sequencer.sv
// Multi-channel PDM setpoint sequencer: accepts one command at a time and
// drives the selected channel's setpoint to the target.
// Macro PDM_SEQUENCER_RAMP_EN: ramp in step increments on prescaled ticks;
// otherwise the setpoint jumps straight to the target.
module pdm_sequencer
  import pdm_sequencer_pkg::*;
#(
  parameter int unsigned NBITS = 11,
  parameter int unsigned NCHAN = 4,
  parameter int unsigned DIV_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [$clog2(NCHAN)-1:0] cmd_chan,
  input  logic [NBITS-1:0]         cmd_value,
  input  logic [NBITS-1:0]         step,
  input  logic [DIV_W-1:0]         tick_div,
  output logic [NCHAN*NBITS-1:0]   data_out,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned CHAN_W    = $clog2(NCHAN);
  localparam int unsigned CHAN_SPAN = 1 << CHAN_W;

  state_e            state_q, state_d;
  logic [CHAN_W-1:0] chan_q, chan_d;
  logic [NBITS-1:0]  tgt_q, tgt_d;
  logic [NBITS-1:0]  sp_q [NCHAN];
  logic [NBITS-1:0]  sp_d [NCHAN];
  logic [CHAN_SPAN-1:0] chan_ok;

`ifdef PDM_SEQUENCER_RAMP_EN
  logic [NBITS-1:0] step_q, step_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [NBITS-1:0] cur_sp;
  logic             ramp_tick;

  pdm_sequencer_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q != RAMP),
    .div    (div_q),
    .tick_c (ramp_tick)
  );

  // Current setpoint of the latched channel.
  always_comb begin
    cur_sp = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (CHAN_W'(k) == chan_q) cur_sp = sp_q[k];
    end
  end
`else
  logic unused_ramp_cfg;
  assign unused_ramp_cfg = ^{step, tick_div};
`endif

  // Channel indices that map to a real channel.
  always_comb begin
    for (int i = 0; i < CHAN_SPAN; i++) chan_ok[i] = (unsigned'(i) < NCHAN);
  end

  // Next-state and setpoint update.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    tgt_d   = tgt_q;
    sp_d    = sp_q;
`ifdef PDM_SEQUENCER_RAMP_EN
    step_d  = step_q;
    div_d   = div_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          chan_d  = cmd_chan;
          tgt_d   = cmd_value;
`ifdef PDM_SEQUENCER_RAMP_EN
          step_d  = step;
          div_d   = tick_div;
`endif
          // Out-of-range channels complete without touching any setpoint.
          state_d = chan_ok[cmd_chan] ? RAMP : DONE;
        end
      end
      RAMP: begin
`ifdef PDM_SEQUENCER_RAMP_EN
        if (cur_sp == tgt_q) begin
          state_d = DONE;
        end else if (ramp_tick) begin
          for (int k = 0; k < NCHAN; k++) begin
            if (CHAN_W'(k) == chan_q) begin
              sp_d[k] = NBITS'(next_setpoint(SP_MAX_W'(cur_sp), SP_MAX_W'(tgt_q),
                                             SP_MAX_W'(step_q)));
            end
          end
        end
`else
        for (int k = 0; k < NCHAN; k++) begin
          if (CHAN_W'(k) == chan_q) sp_d[k] = tgt_q;
        end
        state_d = DONE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, command and setpoint registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      chan_q  <= '0;
      tgt_q   <= '0;
      sp_q    <= '{default: '0};
`ifdef PDM_SEQUENCER_RAMP_EN
      step_q  <= '0;
      div_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      tgt_q   <= tgt_d;
      sp_q    <= sp_d;
`ifdef PDM_SEQUENCER_RAMP_EN
      step_q  <= step_d;
      div_q   <= div_d;
`endif
    end
  end

  for (genvar k = 0; k < NCHAN; k++) begin : g_out
    assign data_out[k*NBITS +: NBITS] = sp_q[k];
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_pdm_sequencer.sv
// Self-checking bench for pdm_sequencer (default parameters).
module tb_pdm_sequencer;

  localparam int NB = 11;
  localparam int NC = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_chan = '0;
  logic [NB-1:0]   cmd_value = '0;
  logic [NB-1:0]   step = '0;
  logic [DW-1:0]   tick_div = '0;
  logic [NC*NB-1:0] data_out;
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_err    = 0;
  int m_sp [NC];

  pdm_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_chan  (cmd_chan),
    .cmd_value (cmd_value),
    .step      (step),
    .tick_div  (tick_div),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [NC*NB-1:0] model_data();
    logic [NC*NB-1:0] v;
    v = '0;
    for (int k = 0; k < NC; k++) v[k*NB +: NB] = NB'(m_sp[k]);
    return v;
  endfunction

  // Issue one command at a negedge with DUT idle and check every cycle until idle again.
  // With hold set, the next command is presented during busy and must stay pending.
  task automatic do_cmd(input string name, input int chan, input int tgt, input int stp,
                        input int div, input bit hold, input int hchan, input int htgt,
                        input int hstp, input int hdiv);
    int vals[$];
    int v, s, n, done_j, last_j, idx;
    logic [NC*NB-1:0] exp_data;
    logic exp_busy, exp_done, exp_ready;
    cmd_valid = 1'b1;
    cmd_chan  = 2'(chan);
    cmd_value = NB'(tgt);
    step      = NB'(stp);
    tick_div  = DW'(div);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_at_issue: got %b want 1", name, cmd_ready);
    end
    v = m_sp[chan];
    vals.push_back(v);
`ifdef PDM_SEQUENCER_RAMP_EN
    s = (stp == 0) ? 1 : stp;
    while (v != tgt) begin
      if (tgt > v) v = (tgt - v <= s) ? tgt : v + s;
      else         v = (v - tgt <= s) ? tgt : v - s;
      vals.push_back(v);
    end
    n = vals.size() - 1;
    done_j = n * (div + 1) + 2;
`else
    s = 0;
    vals.push_back(tgt);
    n = 1;
    done_j = 2;
`endif
    last_j = done_j + 1;
    @(negedge clk);
    if (hold) begin
      cmd_chan  = 2'(hchan);
      cmd_value = NB'(htgt);
      step      = NB'(hstp);
      tick_div  = DW'(hdiv);
    end else begin
      cmd_valid = 1'b0;
    end
    for (int j = 1; j <= last_j; j++) begin
`ifdef PDM_SEQUENCER_RAMP_EN
      idx = (j - 1) / (div + 1);
      if (idx > n) idx = n;
`else
      idx = (j >= 2) ? 1 : 0;
`endif
      m_sp[chan] = vals[idx];
      exp_data  = model_data();
      exp_busy  = (j < last_j);
      exp_done  = (j == done_j);
      exp_ready = (j == last_j);
      n_checks++;
      if ({data_out, busy, done, cmd_ready} !== {exp_data, exp_busy, exp_done, exp_ready}) begin
        n_err++;
        $display("FAIL %s cycle %0d: got data=%h busy=%b done=%b ready=%b, want data=%h busy=%b done=%b ready=%b",
                 name, j, data_out, busy, done, cmd_ready, exp_data, exp_busy, exp_done, exp_ready);
      end
      if (j < last_j) @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if ({data_out, busy, done, cmd_ready} !== {{(NC*NB){1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL %s: got data=%h busy=%b done=%b ready=%b, want data=0 busy=0 done=0 ready=1",
               name, data_out, busy, done, cmd_ready);
    end
  endtask

  task automatic test_reset();
    #1;
    check_reset_outputs("reset_async");
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_held");
    rst = 1'b0;
    for (int k = 0; k < NC; k++) m_sp[k] = 0;
  endtask

  task automatic test_ramp_up();
    do_cmd("ramp_up", 0, 100, 30, 0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_ramp_down();
    do_cmd("preset_ch1", 1, 100, 100, 0, 1'b0, 0, 0, 0, 0);
    do_cmd("ramp_down", 1, 10, 50, 3, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_saturate();
    do_cmd("big_step_2000", 2, 2000, 2047, 0, 1'b0, 0, 0, 0, 0);
    do_cmd("big_step_2047", 2, 2047, 2047, 0, 1'b0, 0, 0, 0, 0);
    do_cmd("zero_step", 2, 2040, 0, 1, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_equal();
    do_cmd("equal_target", 1, 10, 5, 2, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    do_cmd("b2b_first", 0, 700, 200, 1, 1'b1, 3, 55, 20, 0);
    do_cmd("b2b_held", 3, 55, 20, 0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int ch, tg, st, dv;
    for (int i = 0; i < 8; i++) begin
      ch = int'($urandom_range(0, NC - 1));
      dv = int'($urandom_range(0, 3));
      if (i % 3 == 2) begin
        st = 0;
        tg = m_sp[ch] + int'($urandom_range(0, 24)) - 12;
        if (tg < 0) tg = 0;
        if (tg > 2047) tg = 2047;
      end else begin
        st = int'($urandom_range(40, 2047));
        tg = int'($urandom_range(0, 2047));
      end
      do_cmd("random", ch, tg, st, dv, 1'b0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_reset_mid_ramp();
    logic [NC*NB-1:0] exp_data;
    cmd_valid = 1'b1;
    cmd_chan  = 2'd2;
    cmd_value = NB'(1500);
    step      = NB'(100);
    tick_div  = DW'(4);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
`ifdef PDM_SEQUENCER_RAMP_EN
    m_sp[2] = (m_sp[2] < 1500) ? m_sp[2] + 100 : m_sp[2] - 100;
    if ((m_sp[2] > 1500 && m_sp[2] - 100 < 1500) || (m_sp[2] < 1500 && m_sp[2] + 100 > 1500))
      m_sp[2] = 1500;
`else
    m_sp[2] = 1500;
`endif
    exp_data = model_data();
    n_checks++;
    if (data_out !== exp_data) begin
      n_err++;
      $display("FAIL mid_ramp_progress: got %h want %h", data_out, exp_data);
    end
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_ramp");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL no_done_in_reset: got %b want 0", done);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < NC; k++) m_sp[k] = 0;
  endtask

  task automatic test_after_reset();
    do_cmd("after_reset", 0, 5, 0, 0, 1'b0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_saturate();
    test_equal();
    test_back_to_back();
    test_random();
    test_reset_mid_ramp();
    test_after_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
